stopwatch_controller: RTL

- Sequences the BCD stopwatch counter from the Au I/O board push-buttons.
- Debounces three buttons and runs a start/stop/lap/clear state machine.
- Generates the counter tick enable from the 100 MHz board clock.
- Drives the enable, clear and direction inputs of the counter, and selects the live or lap-frozen value for the display and LED driver.

---
 rtl/stopwatch_controller.sv | 102 ++++++++++
 1 files changed

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: debounced start/stop/lap/clear sequencer and tick generator for the BCD stopwatch counter.
// Define STOPWATCH_COUNTDOWN_EN to add count-down direction control and expiry at zero.
module stopwatch_controller #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WIDTH           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  input  logic             dir_sw,
  input  logic [WIDTH-1:0] count_value,
  output logic             count_enable,
  output logic             count_clear,
  output logic             count_up,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       state,
  output logic             expired
);
  localparam int PRE = CLK_HZ / TICK_HZ;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;
  state_t           state_q;
  logic [2:0]       btn, sync1_q, sync2_q, level_q, prev_q, press;
  logic [DW-1:0]    db_cnt_q [3];
  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] lap_q, disp_q;
  logic             en_q, clr_q, up_q, exp_q, clr_ev, ss_ev, lap_ev, run, wrap, expire;
  assign btn    = {btn_clear, btn_lap, btn_start_stop};
  assign press  = level_q & ~prev_q;
  assign clr_ev = press[2];
  assign ss_ev  = press[0] & ~press[2];
  assign lap_ev = press[1] & ~press[0] & ~press[2];
  assign run    = (state_q == RUNNING) || (state_q == LAP);
  assign wrap   = run && (pre_q == PW'(PRE - 1));
`ifdef STOPWATCH_COUNTDOWN_EN
  assign expire = wrap && !up_q && (count_value == '0);
`else
  logic unused_dir;
  assign unused_dir = dir_sw;
  assign expire     = 1'b0;
`endif
  // A level is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      for (int i = 0; i < 3; i++)
        if (sync2_q[i] == level_q[i]) db_cnt_q[i] <= '0;
        else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q[i] <= '0;
          level_q[i]  <= sync2_q[i];
        end else db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      lap_q   <= '0;
      disp_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      up_q    <= 1'b1;
      exp_q   <= 1'b0;
    end else begin
      en_q   <= wrap && !expire;
      clr_q  <= clr_ev && ((state_q == IDLE) || (state_q == PAUSED));
      disp_q <= (state_q == LAP) ? lap_q : count_value;
      pre_q  <= run ? (wrap ? '0 : pre_q + 1'b1) : ((state_q == PAUSED) && !clr_ev) ? pre_q : '0;
      if ((state_q == RUNNING) && lap_ev) lap_q <= count_value;
      case (state_q)
        IDLE:    if (ss_ev) state_q <= RUNNING;
        RUNNING: if (expire) state_q <= IDLE; else if (ss_ev) state_q <= PAUSED; else if (lap_ev) state_q <= LAP;
        LAP:     if (expire) state_q <= IDLE; else if (ss_ev) state_q <= PAUSED; else if (lap_ev) state_q <= RUNNING;
        default: if (ss_ev) state_q <= RUNNING; else if (clr_ev) state_q <= IDLE;
      endcase
`ifdef STOPWATCH_COUNTDOWN_EN
      if (state_q == IDLE) up_q <= ~dir_sw;
      if (expire) exp_q <= 1'b1;
      else if (ss_ev || clr_ev) exp_q <= 1'b0;
`endif
    end
  end
  assign count_enable  = en_q;
  assign count_clear   = clr_q;
  assign count_up      = up_q;
  assign display_value = disp_q;
  assign state         = state_q;
  assign expired       = exp_q;
endmodule
